// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared definitions for the FIFO-draining UART transmitter: FSM state
//   encodings, the line levels used for idle and start bits, and the default
//   parameter values. Imported by the RTL and by the bench.
//   The optional parity state ST_PARITY is only reached when the design is
//   built with `define UART_PARITY_EN.
package fifo_uart_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  // True while a serial frame is on the line (baud counter must run).
  function automatic logic in_frame(input state_e s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; bit_tick is high
//   in the last clk of every bit period. restart holds the count at zero so the
//   first bit of a frame always lasts a full CLKS_PER_BIT clks.
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   restart   in  1 = hold counter at zero
//   bit_tick  out last clk of the current bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage for syn_fifo: pops one byte at a time and serialises it as
//   UART 8N1 (or 8E1 when built with `define UART_PARITY_EN) on tx.
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   tx_en       in   1 = may start a new byte; 0 = finish frame, then idle
//   fifo_empty  in   syn_fifo empty flag
//   fifo_data   in   syn_fifo data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  one-cycle pop strobe
//   tx          out  serial line, idle high, driven from a register
//   busy        out  high from the pop cycle to the last stop-bit clk
//   tx_done     out  one-cycle pulse in the last clk of the stop bit
//   dbg_state   out  current FSM state, for observation only
// Handshake: a pop is fifo_rd_en=1 in a cycle where fifo_empty=0; the FIFO
//   presents the popped word on fifo_data one cycle later and holds it. A pop
//   is only issued in IDLE or in the last clk of STOP, never while empty.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output state_e            dbg_state
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;   // number of data bits already put on the line
  logic              tx_q;
  logic              bit_tick;
  logic              can_pop;
`ifdef UART_PARITY_EN
  logic              parity;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (!in_frame(state)),
    .bit_tick (bit_tick)
  );

  // rst_n gates the strobe so no pop leaks out while reset is held.
  assign can_pop    = rst_n && tx_en && !fifo_empty;
  assign fifo_rd_en = can_pop && ((state == ST_IDLE) || ((state == ST_STOP) && bit_tick));
  assign busy       = (state != ST_IDLE) || fifo_rd_en;
  assign tx_done    = (state == ST_STOP) && bit_tick;
  assign tx         = tx_q;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx_q    <= IDLE_LEVEL;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rd_en) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg   <= fifo_data;
          bit_idx <= '0;
          tx_q    <= START_LEVEL;
          state   <= ST_START;
`ifdef UART_PARITY_EN
          parity  <= ^fifo_data;
`endif
        end
        ST_START: begin
          if (bit_tick) begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IDX_W'(1);
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
`ifdef UART_PARITY_EN
              tx_q    <= parity;
              state   <= ST_PARITY;
`else
              tx_q    <= IDLE_LEVEL;
              state   <= ST_STOP;
`endif
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            tx_q  <= IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // A pop in this clk hands straight over to the next frame.
          if (bit_tick) state <= fifo_rd_en ? ST_FETCH : ST_IDLE;
        end
        default: begin
          tx_q  <= IDLE_LEVEL;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx with a behavioural 16-deep FIFO (one-cycle read
//   latency) in front of it and a bit-sampling monitor decoding tx.
module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int C     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = (W + 2 + PB) * C;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic         tx_en = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd_en, tx, busy, tx_done;
  state_e       dbg_state;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .dbg_state  (dbg_state)
  );

  // behavioural FIFO (not reset by rst_n: its contents survive a DUT reset)
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] fq[$];

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
    if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  // scoreboard and counters
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int pop_cnt = 0, done_cnt = 0, bad_pop_cnt = 0;
  int last_pop_cyc = 0, last_done_cyc = 0, last_start_cyc = 0;
  int start_q[$];

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      if (fifo_empty) bad_pop_cnt++;
    end
    if (tx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // monitor: samples tx one clk into every bit period
  logic         mon_active = 1'b0;
  int           mon_cnt = 0;
  logic [W-1:0] mon_byte = '0;

  always @(negedge clk) begin
    int slot;
    if (!rst_n) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (!mon_active) begin
      if (tx === START_LEVEL) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
        last_start_cyc = cyc;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == 1) begin
        slot = mon_cnt / C;
        if (slot == 0) begin
          checks++;
          if (tx !== START_LEVEL) begin
            $display("FAIL start_bit: got %b want %b", tx, START_LEVEL);
            failures++;
          end
        end else if (slot <= W) begin
          mon_byte[slot-1] = tx;
`ifdef UART_PARITY_EN
        end else if (slot == W + 1) begin
          checks++;
          if (exp_q.size() == 0 || tx !== ^exp_q[0]) begin
            $display("FAIL parity_bit: got %b (queue size %0d)", tx, exp_q.size());
            failures++;
          end
`endif
        end else begin
          checks++;
          if (tx !== IDLE_LEVEL) begin
            $display("FAIL stop_bit: got %b want %b", tx, IDLE_LEVEL);
            failures++;
          end
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL byte_unexpected: got %h want none", mon_byte);
            failures++;
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (mon_byte !== e) begin
              $display("FAIL byte_data: got %h want %h", mon_byte, e);
              failures++;
            end
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [W-1:0] b, input bit expect_out);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_out) exp_q.push_back(b);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && fifo_empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      $display("FAIL %s_timeout: got %0d pending want 0", name, exp_q.size());
      failures++;
    end
  endtask

  task automatic wait_mon(input int cnt, input int budget, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (mon_active && mon_cnt == cnt) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      $display("FAIL %s_timeout: got no bit position %0d want reached", name, cnt);
      failures++;
    end
  endtask

  // tests
  task automatic test_reset();
    int p0;
    #12;
    checks++;
    if (tx !== IDLE_LEVEL || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      $display("FAIL reset_outputs: got tx=%b busy=%b rd=%b want 1 0 0", tx, busy, fifo_rd_en);
      failures++;
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
      failures++;
    end
    #8;
    rst_n = 1'b1;
    tx_en = 1'b1;
    p0 = pop_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== 0 || tx !== IDLE_LEVEL || busy !== 1'b0) begin
      $display("FAIL reset_empty_idle: got pops=%0d tx=%b busy=%b want 0 1 0", pop_cnt - p0, tx, busy);
      failures++;
    end
  endtask

  task automatic test_single();
    int p0, d0;
    p0 = pop_cnt;
    d0 = done_cnt;
    write_byte(8'hA5, 1'b1);
    wait_drain(200, "single");
    repeat (5) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== 1) begin
      $display("FAIL single_pops: got %0d want 1", pop_cnt - p0);
      failures++;
    end
    checks++;
    if (last_start_cyc - last_pop_cyc !== 3) begin
      $display("FAIL single_latency: got %0d want 3", last_start_cyc - last_pop_cyc);
      failures++;
    end
    checks++;
    if (last_done_cyc - last_start_cyc + 1 !== FRAME) begin
      $display("FAIL single_frame_len: got %0d want %0d", last_done_cyc - last_start_cyc + 1, FRAME);
      failures++;
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0);
      failures++;
    end
  endtask

  task automatic test_burst();
    int p0, s0;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = W'($urandom_range(0, 255));
      if (i < DEPTH) exp_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      $display("FAIL burst_hold_idle: got busy=%b rd=%b want 0 0", busy, fifo_rd_en);
      failures++;
    end
    p0 = pop_cnt;
    s0 = start_q.size();
    tx_en = 1'b1;
    wait_drain(DEPTH * (FRAME + 2) + 100, "burst");
    checks++;
    if (start_q.size() - s0 !== DEPTH) begin
      $display("FAIL burst_frames: got %0d want %0d", start_q.size() - s0, DEPTH);
      failures++;
    end
    for (int i = s0 + 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] !== FRAME + 2) begin
        $display("FAIL burst_gap: got %0d want %0d", start_q[i] - start_q[i-1], FRAME + 2);
        failures++;
      end
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      $display("FAIL burst_empty: got %b want 1", fifo_empty);
      failures++;
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pop_cnt - p0 !== DEPTH) begin
      $display("FAIL burst_pops: got %0d want %0d", pop_cnt - p0, DEPTH);
      failures++;
    end
  endtask

  task automatic test_tx_en_drop();
    int p0;
    p0 = pop_cnt;
    write_byte(8'h3C, 1'b1);
    write_byte(W'($urandom_range(0, 255)), 1'b1);
    write_byte(W'($urandom_range(0, 255)), 1'b1);
    wait_mon(3 * C + 1, 100, "drop_mid_data");
    tx_en = 1'b0;
    repeat (FRAME + 60) @(negedge clk);
    checks++;
    if (exp_q.size() !== 2) begin
      $display("FAIL drop_frames_left: got %0d want 2", exp_q.size());
      failures++;
    end
    checks++;
    if (pop_cnt - p0 !== 1 || busy !== 1'b0 || tx !== IDLE_LEVEL) begin
      $display("FAIL drop_idle: got pops=%0d busy=%b tx=%b want 1 0 1", pop_cnt - p0, busy, tx);
      failures++;
    end
    tx_en = 1'b1;
    wait_drain(3 * FRAME + 50, "drop_resume");
    checks++;
    if (pop_cnt - p0 !== 3) begin
      $display("FAIL drop_resume_pops: got %0d want 3", pop_cnt - p0);
      failures++;
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] lost;
    write_byte(W'($urandom_range(0, 255)), 1'b1);
    write_byte(W'($urandom_range(0, 255)), 1'b1);
    write_byte(W'($urandom_range(0, 255)), 1'b1);
    // bit 3 occupies monitor counts 4C..5C-1
    wait_mon(4 * C + 1, 100, "reset_bit3");
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== IDLE_LEVEL || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      $display("FAIL async_reset_outputs: got tx=%b busy=%b rd=%b want 1 0 0", tx, busy, fifo_rd_en);
      failures++;
    end
    lost = exp_q.pop_front();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain(2 * (FRAME + 2) + 50, "after_reset");
    checks++;
    if (exp_q.size() !== 0 || fifo_empty !== 1'b1) begin
      $display("FAIL after_reset_drain: got pending=%0d empty=%b want 0 1 (aborted %h)", exp_q.size(), fifo_empty, lost);
      failures++;
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    write_byte(8'h07, 1'b1);
    wait_drain(FRAME + 50, "parity_07");
    checks++;
    if (last_done_cyc - last_start_cyc + 1 !== 44) begin
      $display("FAIL parity_frame_len: got %0d want 44", last_done_cyc - last_start_cyc + 1);
      failures++;
    end
    write_byte(8'h03, 1'b1);
    wait_drain(FRAME + 50, "parity_03");
  endtask
`endif

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_tx_en_drop();
    test_async_reset();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (bad_pop_cnt !== 0) begin
      $display("FAIL pop_while_empty: got %0d want 0", bad_pop_cnt);
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
